// File: rtl/gshare_predictor_pkg.sv
// Shared types for the branch direction predictor: outcome encoding, indexing mode,
// predictor FSM states and the saturating event-counter helper.
package gshare_predictor_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic {
    PRED_BIMODAL = 1'b0,
    PRED_GSHARE  = 1'b1
  } PredMode;

  typedef enum logic {
    BP_INIT  = 1'b0,
    BP_READY = 1'b1
  } BpState;

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  // Event counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == COUNT_MAX) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gshare_predictor_bp_counter_table.sv
// Table of 2^IDX_W saturating counters: one asynchronous prediction read port and one
// synchronous write port that either loads the weakly-taken value or trains an entry.
module bp_counter_table
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic             wr_init,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] WEAK_TAKEN = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN    = {CTR_W{1'b0}};

  logic [CTR_W-1:0] mem [DEPTH];
  logic [CTR_W-1:0] wr_cur;
  logic [CTR_W-1:0] wr_next;

  assign rd_ctr = mem[rd_idx];
  assign wr_cur = mem[wr_idx];

  // Training is a read-modify-write of the entry being written; the prediction port
  // always sees the pre-update contents in the same cycle.
  always_comb begin
    wr_next = wr_cur;
    if (wr_init) begin
      wr_next = WEAK_TAKEN;
    end else if (wr_taken == TAKEN) begin
      if (wr_cur != CTR_MAX) begin
        wr_next = wr_cur + CTR_ONE;
      end
    end else begin
      if (wr_cur != CTR_MIN) begin
        wr_next = wr_cur - CTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_next;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Bimodal/gshare branch direction predictor: init sweep FSM, non-speculative global
// history, index hash and resolved/mispredicted branch counters around the counter table.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_W  = 10,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 8,
  parameter int MODE   = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_pc,
  input  logic [ADDR_W-1:0] i_req_target,
  output logic              o_req_prediction,
  output logic [HIST_W-1:0] o_req_history,
  input  logic              i_fb_valid,
  input  logic [ADDR_W-1:0] i_fb_pc,
  input  logic [HIST_W-1:0] i_fb_history,
  input  logic              i_fb_prediction,
  input  logic              i_fb_outcome,
  output logic              o_ready,
  output logic [31:0]       o_fb_count,
  output logic [31:0]       o_mispred_count
);

  localparam bit USE_HIST = (MODE == int'(PRED_GSHARE));
  localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);

  BpState            state;
  BpState            state_next;
  logic [IDX_W-1:0]  init_ptr;
  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] ghr_shifted;
  logic [31:0]       fb_count;
  logic [31:0]       mispred_count;

  logic              ready;
  logic              train_en;
  logic              tbl_we;
  logic              tbl_init;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  fb_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [CTR_W-1:0]  req_ctr;
  logic              unused_bits;

  function automatic logic [IDX_W-1:0] hash_idx(input logic [ADDR_W-1:0] pc,
                                                input logic [HIST_W-1:0] hist);
    logic [IDX_W-1:0] mix;
    mix = USE_HIST ? IDX_W'(hist) : '0;
    return pc[IDX_W+1:2] ^ mix;
  endfunction

  assign req_idx = hash_idx(i_req_pc, ghr);
  assign fb_idx  = hash_idx(i_fb_pc, i_fb_history);

  // Request valid and target only matter to the surrounding pipeline.
  assign unused_bits = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc, req_ctr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BP_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BP_INIT:  if (init_ptr == '1) state_next = BP_READY;
      BP_READY: state_next = BP_READY;
      default:  state_next = BP_INIT;
    endcase
  end

  // The single table write port belongs to the sweep in INIT and to training in READY.
  always_comb begin
    ready    = 1'b0;
    tbl_we   = 1'b0;
    tbl_init = 1'b0;
    wr_idx   = fb_idx;
    case (state)
      BP_INIT: begin
        tbl_we   = 1'b1;
        tbl_init = 1'b1;
        wr_idx   = init_ptr;
      end
      BP_READY: begin
        ready  = 1'b1;
        tbl_we = i_fb_valid;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign train_en = ready & i_fb_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_ptr <= '0;
    end else if (state == BP_INIT) begin
      init_ptr <= init_ptr + PTR_ONE;
    end
  end

  generate
    if (HIST_W == 1) begin : g_hist_one
      assign ghr_shifted = i_fb_outcome;
    end else begin : g_hist_many
      assign ghr_shifted = {ghr[HIST_W-2:0], i_fb_outcome};
    end
  endgenerate

  // History is only updated from resolved branches, so it never needs repair.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr           <= '0;
      fb_count      <= '0;
      mispred_count <= '0;
    end else if (train_en) begin
      ghr      <= ghr_shifted;
      fb_count <= sat_inc32(fb_count);
      if (i_fb_prediction != i_fb_outcome) begin
        mispred_count <= sat_inc32(mispred_count);
      end
    end
  end

  bp_counter_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_table (
    .clk      (clk),
    .rd_idx   (req_idx),
    .rd_ctr   (req_ctr),
    .wr_en    (tbl_we),
    .wr_init  (tbl_init),
    .wr_idx   (wr_idx),
    .wr_taken (i_fb_outcome)
  );

  assign o_ready          = ready;
  assign o_req_prediction = ready ? req_ctr[CTR_W-1] : TAKEN;
  assign o_req_history    = ready ? ghr : '0;
  assign o_fb_count       = fb_count;
  assign o_mispred_count  = mispred_count;

endmodule
